// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, latency bounds,
// byte-lane mask constants and a lane-mask expansion helper.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

    // Widens a 4-bit lane enable into a 32-bit bit mask.
    function automatic logic [31:0] laneBits(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with per-byte write enables and a read capture register.
// Contents are never cleared, so there is deliberately no reset.
module dmem_array
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_we,
    input  logic                           i_re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
    input  logic [31:0]                    i_wdata,
    input  logic [3:0]                     i_mask,
    output logic [31:0]                    o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Lanes outside the mask come back as zero so the top never has to re-mask.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_mask[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_idx] & laneBits(i_mask);
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for a hart's load/store port.
// Define DMEM_RESPONDER_CHECK_EN to add request checking and the o_dmem_err port.
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] RESET_ADDR  = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata
`ifdef DMEM_RESPONDER_CHECK_EN
    ,
    output logic        o_dmem_err
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic             r_isRead;

    logic [31:0]      w_offset;
    logic [AW-1:0]    w_idx;
    logic [31-AW:0]   w_unusedOffset;
    logic             w_request;
    logic             w_accept;
    logic             w_bad;
    logic             w_doWrite;
    logic             w_doRead;
    logic [31:0]      w_arrayRdata;

    // Upper offset bits simply wrap around the array.
    assign w_offset       = i_dmem_addr - RESET_ADDR;
    assign w_idx          = w_offset[AW+1:2];
    assign w_unusedOffset = {w_offset[31:AW+2], w_offset[1:0]};

`ifdef DMEM_RESPONDER_CHECK_EN
    logic r_err;
    assign w_bad = (i_dmem_ren & i_dmem_wen) | (i_dmem_addr[1:0] != 2'b00);
`else
    assign w_bad = 1'b0;
`endif

    assign w_request = i_dmem_ren | i_dmem_wen;
    assign w_accept  = i_rst_n & (r_state == IDLE) & w_request;
    assign w_doWrite = w_accept & i_dmem_wen & ~w_bad;
    assign w_doRead  = w_accept & i_dmem_ren & ~i_dmem_wen & ~w_bad;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .i_clk  (i_clk),
        .i_we   (w_doWrite),
        .i_re   (w_doRead),
        .i_idx  (w_idx),
        .i_wdata(i_dmem_wdata),
        .i_mask (i_dmem_mask),
        .o_rdata(w_arrayRdata)
    );

    // The counter holds the remaining WAIT cycles; RESP is entered when it reads 1.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_isRead <= 1'b0;
`ifdef DMEM_RESPONDER_CHECK_EN
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    if (w_request) begin
                        r_isRead <= w_doRead;
`ifdef DMEM_RESPONDER_CHECK_EN
                        r_err    <= w_bad;
`endif
                        if (LATENCY == 1) begin
                            r_state <= RESP;
                            r_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= RESP;
                        r_valid <= 1'b1;
                    end
                end
                RESP: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_dmem_ready = (r_state == IDLE);
    assign o_dmem_valid = r_valid;
    // Writes and errored requests answer with zero data.
    assign o_dmem_rdata = (r_valid & r_isRead) ? w_arrayRdata : 32'h0;
`ifdef DMEM_RESPONDER_CHECK_EN
    assign o_dmem_err   = r_valid & r_err;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH_WORDS=256, LATENCY=2): vector table,
// response scoreboard, reset corner cases; honours DMEM_RESPONDER_CHECK_EN if defined.
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;
`ifdef DMEM_RESPONDER_CHECK_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk;
    logic        rstN;
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        ready;
    logic        valid;
    logic [31:0] rdata;
`ifdef DMEM_RESPONDER_CHECK_EN
    logic        err;
`endif

    int    checks   = 0;
    int    failures = 0;
    vec_t  vecs[$];
    resp_t sb[$];
    resp_t expResp;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LAT),
        .RESET_ADDR (32'h0000_0000)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_dmem_addr (addr),
        .i_dmem_ren  (ren),
        .i_dmem_wen  (wen),
        .i_dmem_wdata(wdata),
        .i_dmem_mask (mask),
        .o_dmem_ready(ready),
        .o_dmem_valid(valid),
        .o_dmem_rdata(rdata)
`ifdef DMEM_RESPONDER_CHECK_EN
        ,
        .o_dmem_err  (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic void addVec(input logic r, input logic w, input logic [31:0] a,
                                   input logic [31:0] d, input logic [3:0] m,
                                   input logic [31:0] e, input logic er);
        vec_t v;
        v.ren = r; v.wen = w; v.addr = a; v.wdata = d; v.mask = m;
        v.expRdata = e; v.expErr = er;
        vecs.push_back(v);
    endfunction

    // Every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected valid", 32'd1, 32'd0);
            end else begin
                expResp = sb.pop_front();
                checkOutput("resp rdata", rdata, expResp.rdata);
`ifdef DMEM_RESPONDER_CHECK_EN
                checkOutput("resp err", {31'b0, err}, {31'b0, expResp.err});
`endif
            end
        end else begin
            checkOutput("rdata while not valid", rdata, 32'h0);
        end
    end

    task automatic waitReady(input string name);
        int waited = 0;
        @(negedge clk);
        while (!ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({name, " ready before request"}, {31'b0, ready}, 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        waitReady(name);
        ren   = v.ren;
        wen   = v.wen;
        addr  = v.addr;
        wdata = v.wdata;
        mask  = v.mask;
        sb.push_back('{v.expRdata, v.expErr});
        @(posedge clk);
        #1;
        ren = 1'b0;
        wen = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            checkOutput($sformatf("%s ready/valid cycle %0d", name, k), {30'b0, ready, valid},
                        (k <= LAT) ? {31'b0, (k == LAT)} : 32'b10);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t v;
        rstN = 1'b0; ren = 1'b0; wen = 1'b0;
        addr = '0; wdata = '0; mask = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset valid", {31'b0, valid}, 32'd0);
        checkOutput("reset rdata", rdata, 32'h0);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("ready after reset", {31'b0, ready}, 32'd1);

        addVec(0, 1, 32'h10,       32'hDEADBEEF, 4'b1111, 32'h0, 1'b0);
        addVec(0, 1, 32'h13,       32'h55000000, 4'b1000, 32'h0, CE);
        addVec(1, 0, 32'h10,       32'h0,        4'b1111, CE ? 32'hDEADBEEF : 32'h55ADBEEF, 1'b0);
        addVec(1, 0, 32'h10,       32'h0,        4'b1100, CE ? 32'hDEAD0000 : 32'h55AD0000, 1'b0);
        addVec(0, 1, 32'h400,      32'h12345678, 4'b1111, 32'h0, 1'b0);
        addVec(1, 0, 32'h000,      32'h0,        4'b1111, 32'h12345678, 1'b0);
        addVec(1, 0, 32'h400,      32'h0,        4'b0011, 32'h00005678, 1'b0);
        addVec(0, 1, 32'h20,       32'hA5A5A5A5, 4'b1111, 32'h0, 1'b0);
        addVec(0, 1, 32'h20,       32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0);
        addVec(1, 0, 32'h20,       32'h0,        4'b0000, 32'h0, 1'b0);
        addVec(1, 0, 32'h20,       32'h0,        4'b1111, 32'hA5A5A5A5, 1'b0);
        addVec(0, 1, 32'h24,       32'h11223344, 4'b1111, 32'h0, 1'b0);
        addVec(1, 1, 32'h24,       32'h99999999, 4'b1111, 32'h0, CE);
        addVec(1, 0, 32'h24,       32'h0,        4'b1111, CE ? 32'h11223344 : 32'h99999999, 1'b0);
        addVec(0, 1, 32'h26,       32'h0000BEEF, 4'b0011, 32'h0, CE);
        addVec(1, 0, 32'h24,       32'h0,        4'b1111, CE ? 32'h11223344 : 32'h9999BEEF, 1'b0);
        addVec(0, 1, 32'hFFFFFFFC, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0);
        addVec(1, 0, 32'h3FC,      32'h0,        4'b1111, 32'hCAFEF00D, 1'b0);
        addVec(1, 0, 32'h10,       32'h0,        4'b0001, 32'h000000EF, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset right after a read is accepted: no response may ever appear.
        waitReady("rst-mid");
        ren = 1'b1; addr = 32'h10; mask = 4'b1111;
        @(posedge clk);
        #1;
        ren  = 1'b0;
        rstN = 1'b0;
        wen = 1'b1; addr = 32'h10; wdata = 32'h0; mask = 4'b1111;
        @(negedge clk);
        checkOutput("rst-mid valid during reset", {31'b0, valid}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        wen  = 1'b0;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rst-mid ready after release", {31'b0, ready}, 32'd1);
        for (int k = 0; k < LAT + 1; k++) begin
            @(negedge clk);
            checkOutput($sformatf("rst-mid no valid %0d", k), {31'b0, valid}, 32'd0);
        end
        v = '{1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, CE ? 32'hDEADBEEF : 32'h55ADBEEF, 1'b0};
        applyStimulus(v, "rst-mid reread");

`ifdef DMEM_RESPONDER_CHECK_EN
        v = '{1'b1, 1'b1, 32'h10, 32'h01020304, 4'b1111, 32'h0, 1'b1};
        applyStimulus(v, "chk both");
        v = '{1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0};
        applyStimulus(v, "chk unchanged");
        v = '{1'b1, 1'b0, 32'h11, 32'h0, 4'b1111, 32'h0, 1'b1};
        applyStimulus(v, "chk misaligned");
`endif

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, 16..65536.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to response; legal range 1..15.
REQ-003 SHALL have parameter RESET_ADDR, default 32'h00000000: byte address that maps to word 0.
REQ-004 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port i_dmem_addr, input, 32: request byte address from the hart.
REQ-007 SHALL have port i_dmem_ren, input, 1: read request.
REQ-008 SHALL have port i_dmem_wen, input, 1: write request.
REQ-009 SHALL have port i_dmem_wdata, input, 32: write data, already shifted into its byte lanes.
REQ-010 SHALL have port i_dmem_mask, input, 4: byte-lane enable; bit n selects bits [8n+7:8n].
REQ-011 SHALL have port o_dmem_ready, output, 1: the block accepts a request this cycle.
REQ-012 SHALL have port o_dmem_valid, output, 1: one-cycle response pulse, for a read or a write acknowledge.
REQ-013 SHALL have port o_dmem_rdata, output, 32: read data, valid while o_dmem_valid is high.
REQ-014 SHALL have port o_dmem_err, output, 1: error flag, qualified by o_dmem_valid; present only with the macro in REQ-030.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP; o_dmem_ready = (state == IDLE).
REQ-016 SHALL accept a request at a rising edge where state is IDLE and (i_dmem_ren | i_dmem_wen) = 1; the remaining request inputs are don't-care outside that edge.
REQ-017 SHALL compute word index = ((i_dmem_addr - RESET_ADDR) >> 2) modulo DEPTH_WORDS; upper bits wrap and raise no fault.
REQ-018 SHALL commit an accepted write at the acceptance edge, writing only the lanes enabled in i_dmem_mask; the other lanes keep their values.
REQ-019 SHALL capture read data at the acceptance edge, after any earlier write; lanes outside i_dmem_mask SHALL read as 0.
REQ-020 SHALL go IDLE->RESP on acceptance when LATENCY = 1; otherwise IDLE->WAIT, load a counter with LATENCY-1, decrement it each cycle, and go WAIT->RESP when it reaches 1.
REQ-021 SHALL drive o_dmem_valid = 1 only in RESP, exactly LATENCY cycles after the acceptance edge, then go RESP->IDLE; throughput is one request per LATENCY+1 cycles.
REQ-022 SHALL drive o_dmem_rdata = 0 on write responses and whenever o_dmem_valid = 0.
REQ-023 SHALL treat mask 4'b0000 as a legal request: it is accepted and answered, no bytes are written, and rdata = 0.
REQ-024 SHALL give write priority when i_dmem_ren and i_dmem_wen are both high and the macro is absent: the request is handled as a write.
REQ-025 SHALL ignore i_dmem_addr[1:0] when the macro is absent.

Reset
REQ-026 SHALL, while i_rst_n = 0 at an edge, force state to IDLE, the counter to 0, o_dmem_valid to 0, o_dmem_rdata to 0 and o_dmem_err to 0; o_dmem_ready = 1 on the first cycle after reset.
REQ-027 SHALL discard any in-flight response on reset mid-operation; a write already committed stays committed.
REQ-028 SHALL NOT clear storage contents on reset.
REQ-029 SHALL NOT accept a request at an edge where i_rst_n = 0.

Configuration
REQ-030 SHALL compile in request checking and the o_dmem_err port when macro DMEM_RESPONDER_CHECK_EN is defined.
REQ-031 SHALL, with DMEM_RESPONDER_CHECK_EN defined, answer a request with ren & wen both set, or with addr[1:0] != 0, using o_dmem_err = 1 and rdata = 0, with no storage change and normal latency.
REQ-032 SHALL, without DMEM_RESPONDER_CHECK_EN, omit the o_dmem_err port and behave per REQ-024 and REQ-025.

Structure
REQ-033 SHALL place FSM state encodings, the LATENCY bounds and the lane-mask constants (MASK_B0..B3, MASK_H0/H1, MASK_W) in shared package dmem_resp_pkg.
REQ-034 SHALL implement storage in one sub-module, dmem_array: a masked-byte-write, synchronous-capture word array parameterised by DEPTH_WORDS.

Verification
REQ-035 SHALL cover write timing with LATENCY = 2: write 0xDEADBEEF, mask 4'b1111, addr 0x10 accepted at cycle 0 -> ready = 0 in cycles 1-2, valid = 1 only in cycle 2, ready = 1 in cycle 3.
REQ-036 SHALL cover a masked byte write: after REQ-035, write 0x55000000, mask 4'b1000, addr 0x13 (macro off), then read addr 0x10, mask 4'b1111 -> rdata = 0x55ADBEEF.
REQ-037 SHALL cover a masked half-word read: read addr 0x10, mask 4'b1100 -> rdata = 0x55AD0000.
REQ-038 SHALL cover address wrap with DEPTH_WORDS = 256: write 0x12345678 at addr 0x400, then read addr 0x000 -> rdata = 0x12345678.
REQ-039 SHALL cover reset mid-operation: read accepted at cycle 0, i_rst_n = 0 at cycle 1 -> no valid pulse at all, ready = 1 after release, the next read returns the stored data.
REQ-040 SHALL cover checking with DMEM_RESPONDER_CHECK_EN: ren = wen = 1 at addr 0x10 -> valid with err = 1 and word 0x10 unchanged; read addr 0x11 -> valid with err = 1 and rdata = 0.
